sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Parametrised N-master to one-slave arbiter for the sram-like handshake (req/addr_ok/data_ok). It lets the pipeline's fetch and memory stages, plus later masters such as a cache refill port, share one memory port ahead of the AXI bridge. It supports fixed-priority or round-robin grant and tracks up to DEPTH outstanding transactions in an ID FIFO. Responses from the slave are routed back in issue order.

## Interface

**Parameters**
- `N_MST`, default 2: number of masters (2..8).
- `DEPTH`, default 4: maximum outstanding accepted-but-unanswered transactions; power of two, 2..16.
- `RR`, default 0: grant mode. 0 = fixed priority (index 0 highest); 1 = round-robin.
- `AW`, default 32: address width.
- `DW`, default 32: data width; `DW/8` strobe bits.

**Ports**
- `clk` in 1: clock; all state changes on the rising edge.
- `resetn` in 1: synchronous reset, active-low.
- `m_req` in N_MST: per-master request, held until its `m_addr_ok`.
- `m_wr` in N_MST: 1 = write.
- `m_size` in 2*N_MST: byte count code (0 = 1 B, 1 = 2 B, 2 = 4 B).
- `m_wstrb` in (DW/8)*N_MST: write byte strobes.
- `m_addr` in AW*N_MST: address, master i at bits [i*AW +: AW].
- `m_wdata` in DW*N_MST: write data.
- `m_addr_ok` out N_MST: request accepted (one-hot or zero).
- `m_data_ok` out N_MST: response returned (one-hot or zero).
- `m_rdata` out DW: read data, broadcast to all masters and valid with `m_data_ok`.
- `s_req`, `s_wr`, `s_size`, `s_wstrb`, `s_addr`, `s_wdata` out (widths 1, 1, 2, DW/8, AW, DW): slave request.
- `s_addr_ok` in 1: slave accepted the request.
- `s_data_ok` in 1: slave response; responses arrive in request order.
- `s_rdata` in DW: slave read data.
- `outstanding` out clog2(DEPTH+1): current FIFO occupancy.
- `err` out 1: sticky protocol error.

## Operation

- **Accept event:** `acc = s_req & s_addr_ok`. **Return event:** `ret = s_data_ok & ~empty`.
- **Grant:**
  - Computed combinationally from `m_req` when `lock` = 0.
  - RR = 0: lowest set index wins.
  - RR = 1: first set index at or after `rr_ptr`, searching cyclically.
- **Lock:**
  - If `s_req` = 1 and `acc` = 0 at a clock edge, latch `lock` = 1 and `lock_id` = grant.
  - While locked, grant = `lock_id` regardless of other requests, so slave fields stay stable.
  - `acc` clears `lock`.
- **Slave request:**
  - `s_req = |m_req & ~full & resetn`.
  - All other `s_*` fields are muxed from the granted master.
- **On `acc`:**
  - `m_addr_ok[grant]` = 1 in the same cycle.
  - Push grant ID into the FIFO.
  - If RR = 1, set `rr_ptr = (grant+1) mod N_MST`.
- **On `ret`:**
  - `m_data_ok[head]` = 1 in the same cycle, with `m_rdata = s_rdata`.
  - Pop the FIFO.
- **Simultaneous push and pop:** occupancy unchanged; pointers both advance and wrap modulo DEPTH.
- **Full:**
  - `s_req` is forced to 0, even if a pop occurs in the same cycle. This keeps `s_data_ok` out of the combinational path to `s_req`.
  - A locked request stays locked while full.
- **Spurious response:** `s_data_ok` while empty sets `err` = 1 until reset. `m_data_ok` stays 0 and FIFO state is unchanged.
- **Reset (`resetn` = 0 at an edge):**
  - FIFO empty, `outstanding` = 0, `lock` = 0, `rr_ptr` = 0, `err` = 0.
  - While `resetn` = 0, `s_req`, `m_addr_ok` and `m_data_ok` are all 0.
  - Reset mid-transaction discards all tracked IDs. Responses arriving after reset count as spurious.

## Timing

- Request path is combinational: an `m_req` to `s_req` decision in the same cycle, with zero added latency.
- `addr_ok` and `data_ok` are forwarded combinationally in the cycle they arrive.
- Back-to-back issue: one accept per cycle maximum; a new master can be granted in the cycle after an accept.
- `outstanding`, `lock`, `rr_ptr` and `err` are registered: they update at the edge following the event.
- Response throughput: one per cycle; response order equals accept order.

## Test plan

- **Single read:** N_MST=2; master 1 requests address 0x1c000000 and the slave gives `addr_ok` the same cycle → `m_addr_ok` = 2'b10. Slave returns `data_ok` 3 cycles later with 0xdeadbeef → `m_data_ok` = 2'b10, `m_rdata` = 0xdeadbeef, `outstanding` 1→0.
- **Fixed priority:** RR=0; both masters request continuously and the slave always accepts → master 0 wins every cycle and master 1 is starved. RR=1 under the same stimulus → grants alternate 0,1,0,1.
- **Lock:** master 1 is granted with `s_addr_ok` = 0 for 3 cycles, then master 0 raises `m_req` → `s_addr` stays at master 1's address until accept, and master 0 is granted next.
- **Full and wrap:** DEPTH=2 with no responses → third request sees `s_req` = 0 and `outstanding` = 2. Return one response, with pop and push on alternating cycles for 10 transactions → IDs are routed correctly across pointer wrap.
- **Simultaneous accept and return:** at occupancy 1, a new accept and a response occur in the same cycle → `outstanding` stays 1, and the older ID receives `m_data_ok`.
- **Reset and error:** assert `resetn` = 0 with 2 outstanding, release it, then drive `s_data_ok` → `m_data_ok` = 0 and `err` = 1 the next cycle, held until the next reset.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// N-master to one-slave arbiter for the sram-like req/addr_ok/data_ok handshake.
// Accepted master IDs are queued so in-order slave responses are steered back to their owners.
module sram_like_arbiter #(
    parameter int N_MST = 2,
    parameter int DEPTH = 4,
    parameter int RR    = 0,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [N_MST-1:0]              m_req,
    input  logic [N_MST-1:0]              m_wr,
    input  logic [2*N_MST-1:0]            m_size,
    input  logic [(DW/8)*N_MST-1:0]       m_wstrb,
    input  logic [AW*N_MST-1:0]           m_addr,
    input  logic [DW*N_MST-1:0]           m_wdata,
    output logic [N_MST-1:0]              m_addr_ok,
    output logic [N_MST-1:0]              m_data_ok,
    output logic [DW-1:0]                 m_rdata,
    output logic                          s_req,
    output logic                          s_wr,
    output logic [1:0]                    s_size,
    output logic [DW/8-1:0]               s_wstrb,
    output logic [AW-1:0]                 s_addr,
    output logic [DW-1:0]                 s_wdata,
    input  logic                          s_addr_ok,
    input  logic                          s_data_ok,
    input  logic [DW-1:0]                 s_rdata,
    output logic [$clog2(DEPTH+1)-1:0]    outstanding,
    output logic                          err
);

    localparam int IDW = $clog2(N_MST);
    localparam int PW  = $clog2(DEPTH);
    localparam int OW  = $clog2(DEPTH+1);
    localparam int SW  = DW/8;
    localparam logic [OW-1:0]  FULL_CNT = OW'(DEPTH);
    localparam logic [IDW:0]   N_ID     = (IDW+1)'(N_MST);

    logic [IDW-1:0] fifo_q [DEPTH];
    logic [IDW-1:0] fifo_d [DEPTH];
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [OW-1:0]  count_q, count_d;
    logic           lock_q, lock_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           err_q, err_d;

    logic [IDW-1:0] grant_free;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] head_id;
    logic [IDW:0]   search_idx;
    logic [IDW:0]   rr_next;
    logic           search_found;
    logic           full;
    logic           empty;
    logic           acc;
    logic           ret;
    logic           spurious;

    // Cyclic search from rr_ptr; in fixed-priority mode rr_ptr never leaves 0,
    // so the same search degenerates to lowest-index-wins.
    always_comb begin
        grant_free   = '0;
        search_found = 1'b0;
        search_idx   = '0;
        for (int i = 0; i < N_MST; i++) begin
            search_idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (search_idx >= N_ID) begin
                search_idx = search_idx - N_ID;
            end
            if (!search_found && m_req[search_idx[IDW-1:0]]) begin
                search_found = 1'b1;
                grant_free   = search_idx[IDW-1:0];
            end
        end
    end

    assign grant    = lock_q ? lock_id_q : grant_free;
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign s_req    = (|m_req) & ~full & resetn;
    assign acc      = s_req & s_addr_ok;
    assign head_id  = fifo_q[rptr_q];
    assign ret      = s_data_ok & ~empty & resetn;
    assign spurious = s_data_ok & empty & resetn;
    assign m_rdata  = s_rdata;
    assign outstanding = count_q;
    assign err      = err_q;

    always_comb begin
        s_wr    = 1'b0;
        s_size  = '0;
        s_wstrb = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (grant == IDW'(i)) begin
                s_wr    = m_wr[i];
                s_size  = m_size[2*i +: 2];
                s_wstrb = m_wstrb[SW*i +: SW];
                s_addr  = m_addr[AW*i +: AW];
                s_wdata = m_wdata[DW*i +: DW];
            end
        end
    end

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < N_MST; i++) begin
            m_addr_ok[i] = acc & (grant == IDW'(i));
            m_data_ok[i] = ret & (head_id == IDW'(i));
        end
    end

    always_comb begin
        fifo_d    = fifo_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        err_d     = err_q | spurious;
        rr_next   = '0;

        if (acc) begin
            fifo_d[wptr_q] = grant;
            wptr_d         = wptr_q + 1'b1;
        end
        if (ret) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({acc, ret})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A stalled request pins the grant so the slave sees stable fields until it accepts.
        if (acc) begin
            lock_d = 1'b0;
        end else if (s_req) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end

        if (acc && (RR != 0)) begin
            rr_next = {1'b0, grant} + 1'b1;
            if (rr_next >= N_ID) begin
                rr_next = '0;
            end
            rr_ptr_d = rr_next[IDW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
        end
    end

    // ID storage needs no reset: entries are only read behind a non-empty count.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: directed scenarios on a fixed-priority DEPTH=2 instance and
// round-robin plus randomized model-checked traffic on a three-master DEPTH=4 instance.
module tb_sram_like_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    int total = 0;
    int bad   = 0;

    logic [1:0]  a_m_req, a_m_wr, a_m_addr_ok, a_m_data_ok;
    logic [3:0]  a_m_size;
    logic [7:0]  a_m_wstrb;
    logic [63:0] a_m_addr, a_m_wdata;
    logic [31:0] a_m_rdata, a_s_addr, a_s_wdata, a_s_rdata;
    logic        a_s_req, a_s_wr, a_s_addr_ok, a_s_data_ok, a_err;
    logic [1:0]  a_s_size, a_outstanding;
    logic [3:0]  a_s_wstrb;

    logic [2:0]  b_m_req, b_m_wr, b_m_addr_ok, b_m_data_ok;
    logic [5:0]  b_m_size;
    logic [11:0] b_m_wstrb;
    logic [95:0] b_m_addr, b_m_wdata;
    logic [31:0] b_m_rdata, b_s_addr, b_s_wdata, b_s_rdata;
    logic        b_s_req, b_s_wr, b_s_addr_ok, b_s_data_ok, b_err;
    logic [1:0]  b_s_size;
    logic [3:0]  b_s_wstrb;
    logic [2:0]  b_outstanding;

    sram_like_arbiter #(.N_MST(2), .DEPTH(2), .RR(0), .AW(32), .DW(32)) dut_a (
        .clk(clk), .resetn(resetn),
        .m_req(a_m_req), .m_wr(a_m_wr), .m_size(a_m_size), .m_wstrb(a_m_wstrb),
        .m_addr(a_m_addr), .m_wdata(a_m_wdata),
        .m_addr_ok(a_m_addr_ok), .m_data_ok(a_m_data_ok), .m_rdata(a_m_rdata),
        .s_req(a_s_req), .s_wr(a_s_wr), .s_size(a_s_size), .s_wstrb(a_s_wstrb),
        .s_addr(a_s_addr), .s_wdata(a_s_wdata),
        .s_addr_ok(a_s_addr_ok), .s_data_ok(a_s_data_ok), .s_rdata(a_s_rdata),
        .outstanding(a_outstanding), .err(a_err)
    );

    sram_like_arbiter #(.N_MST(3), .DEPTH(4), .RR(1), .AW(32), .DW(32)) dut_b (
        .clk(clk), .resetn(resetn),
        .m_req(b_m_req), .m_wr(b_m_wr), .m_size(b_m_size), .m_wstrb(b_m_wstrb),
        .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_addr_ok(b_m_addr_ok), .m_data_ok(b_m_data_ok), .m_rdata(b_m_rdata),
        .s_req(b_s_req), .s_wr(b_s_wr), .s_size(b_s_size), .s_wstrb(b_s_wstrb),
        .s_addr(b_s_addr), .s_wdata(b_s_wdata),
        .s_addr_ok(b_s_addr_ok), .s_data_ok(b_s_data_ok), .s_rdata(b_s_rdata),
        .outstanding(b_outstanding), .err(b_err)
    );

    task automatic a_idle();
        a_m_req = '0; a_m_wr = '0; a_m_size = '0; a_m_wstrb = '0;
        a_m_addr = '0; a_m_wdata = '0;
        a_s_addr_ok = 1'b0; a_s_data_ok = 1'b0; a_s_rdata = '0;
    endtask

    task automatic b_idle();
        b_m_req = '0; b_m_wr = '0; b_m_size = '0; b_m_wstrb = '0;
        b_m_addr = '0; b_m_wdata = '0;
        b_s_addr_ok = 1'b0; b_s_data_ok = 1'b0; b_s_rdata = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        a_idle(); b_idle();
        a_m_req = 2'b11; a_s_addr_ok = 1'b1; a_s_data_ok = 1'b1;
        b_m_req = 3'b111; b_s_addr_ok = 1'b1; b_s_data_ok = 1'b1;
        #1;
        total++; if (a_s_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_s_req got=%b want=0", a_s_req); end
        total++; if (a_m_addr_ok !== 2'b00) begin bad++; $display("[TB] FAIL reset_addr_ok got=%b want=00", a_m_addr_ok); end
        total++; if (a_m_data_ok !== 2'b00) begin bad++; $display("[TB] FAIL reset_data_ok got=%b want=00", a_m_data_ok); end
        total++; if (b_s_req !== 1'b0 || b_m_addr_ok !== 3'b000) begin bad++; $display("[TB] FAIL reset_b_req got=%b/%b want=0/000", b_s_req, b_m_addr_ok); end
        @(negedge clk);
        a_idle(); b_idle();
        resetn = 1'b1;
        #1;
        total++; if (a_outstanding !== 2'd0 || a_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_state_a got=%0d/%b want=0/0", a_outstanding, a_err); end
        total++; if (b_outstanding !== 3'd0 || b_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_state_b got=%0d/%b want=0/0", b_outstanding, b_err); end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        a_idle();
        a_m_req = 2'b10; a_m_addr[63:32] = 32'h1c00_0000; a_s_addr_ok = 1'b1;
        #1;
        total++; if (a_s_req !== 1'b1 || a_s_addr !== 32'h1c00_0000) begin bad++; $display("[TB] FAIL single_s_req got=%b/%h want=1/1c000000", a_s_req, a_s_addr); end
        total++; if (a_m_addr_ok !== 2'b10) begin bad++; $display("[TB] FAIL single_addr_ok got=%b want=10", a_m_addr_ok); end
        @(negedge clk);
        a_m_req = '0; a_s_addr_ok = 1'b0;
        #1;
        total++; if (a_outstanding !== 2'd1) begin bad++; $display("[TB] FAIL single_outstanding1 got=%0d want=1", a_outstanding); end
        @(negedge clk);
        @(negedge clk);
        a_s_data_ok = 1'b1; a_s_rdata = 32'hdead_beef;
        #1;
        total++; if (a_m_data_ok !== 2'b10) begin bad++; $display("[TB] FAIL single_data_ok got=%b want=10", a_m_data_ok); end
        total++; if (a_m_rdata !== 32'hdead_beef) begin bad++; $display("[TB] FAIL single_rdata got=%h want=deadbeef", a_m_rdata); end
        @(negedge clk);
        a_idle();
        #1;
        total++; if (a_outstanding !== 2'd0) begin bad++; $display("[TB] FAIL single_outstanding0 got=%0d want=0", a_outstanding); end
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        a_idle();
        a_m_req = 2'b11; a_m_addr = {32'h0000_2000, 32'h0000_1000}; a_s_addr_ok = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(negedge clk);
                a_s_data_ok = 1'b1;
            end
            #1;
            total++; if (a_m_addr_ok !== 2'b01) begin bad++; $display("[TB] FAIL prio_grant cycle=%0d got=%b want=01", c, a_m_addr_ok); end
            if (c > 0) begin
                total++; if (a_m_data_ok !== 2'b01) begin bad++; $display("[TB] FAIL prio_data_ok cycle=%0d got=%b want=01", c, a_m_data_ok); end
            end
        end
        @(negedge clk);
        a_m_req = '0; a_s_addr_ok = 1'b0; a_s_data_ok = 1'b1;
        #1;
        total++; if (a_m_data_ok !== 2'b01) begin bad++; $display("[TB] FAIL prio_drain got=%b want=01", a_m_data_ok); end
        @(negedge clk);
        a_idle();
        #1;
        total++; if (a_outstanding !== 2'd0) begin bad++; $display("[TB] FAIL prio_empty got=%0d want=0", a_outstanding); end
    endtask

    task automatic test_lock();
        @(negedge clk);
        a_idle();
        a_m_req = 2'b10; a_m_addr = {32'h0000_a100, 32'h0000_a000};
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            total++; if (a_s_req !== 1'b1 || a_s_addr !== 32'h0000_a100 || a_m_addr_ok !== 2'b00) begin
                bad++; $display("[TB] FAIL lock_wait cycle=%0d got=%b/%h/%b want=1/0000a100/00", c, a_s_req, a_s_addr, a_m_addr_ok);
            end
        end
        @(negedge clk);
        a_m_req = 2'b11;
        #1;
        total++; if (a_s_addr !== 32'h0000_a100) begin bad++; $display("[TB] FAIL lock_hold got=%h want=0000a100", a_s_addr); end
        @(negedge clk);
        a_s_addr_ok = 1'b1;
        #1;
        total++; if (a_m_addr_ok !== 2'b10 || a_s_addr !== 32'h0000_a100) begin bad++; $display("[TB] FAIL lock_accept got=%b/%h want=10/0000a100", a_m_addr_ok, a_s_addr); end
        @(negedge clk);
        a_m_req = 2'b01;
        #1;
        total++; if (a_m_addr_ok !== 2'b01 || a_s_addr !== 32'h0000_a000) begin bad++; $display("[TB] FAIL lock_next got=%b/%h want=01/0000a000", a_m_addr_ok, a_s_addr); end
        @(negedge clk);
        a_m_req = '0; a_s_addr_ok = 1'b0;
        #1;
        total++; if (a_outstanding !== 2'd2) begin bad++; $display("[TB] FAIL lock_outstanding got=%0d want=2", a_outstanding); end
    endtask

    // Entered with two outstanding IDs: master 1 then master 0.
    task automatic test_full_wrap();
        int exp_q[$];
        int g;
        logic [1:0] r;
        logic [31:0] rd;
        exp_q = '{1, 0};
        @(negedge clk);
        a_m_req = 2'b10; a_m_addr[63:32] = 32'h0000_b000; a_s_addr_ok = 1'b1;
        #1;
        total++; if (a_s_req !== 1'b0 || a_m_addr_ok !== 2'b00) begin bad++; $display("[TB] FAIL full_block got=%b/%b want=0/00", a_s_req, a_m_addr_ok); end
        total++; if (a_outstanding !== 2'd2) begin bad++; $display("[TB] FAIL full_count got=%0d want=2", a_outstanding); end
        @(negedge clk);
        a_s_data_ok = 1'b1; a_s_rdata = 32'h1111_1111;
        #1;
        total++; if (a_m_data_ok !== 2'b10) begin bad++; $display("[TB] FAIL full_pop got=%b want=10", a_m_data_ok); end
        total++; if (a_s_req !== 1'b0) begin bad++; $display("[TB] FAIL full_pop_req got=%b want=0", a_s_req); end
        void'(exp_q.pop_front());
        @(negedge clk);
        a_s_data_ok = 1'b0;
        #1;
        total++; if (a_m_addr_ok !== 2'b10) begin bad++; $display("[TB] FAIL full_refill got=%b want=10", a_m_addr_ok); end
        exp_q.push_back(1);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            a_m_req = '0; a_s_addr_ok = 1'b0; a_s_data_ok = 1'b1;
            rd = $urandom; a_s_rdata = rd;
            #1;
            total++; if (a_m_data_ok !== 2'(1 << exp_q[0]) || a_m_rdata !== rd) begin
                bad++; $display("[TB] FAIL wrap_pop t=%0d got=%b/%h want=%b/%h", t, a_m_data_ok, a_m_rdata, 2'(1 << exp_q[0]), rd);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
            r = 2'($urandom_range(1, 3));
            g = r[0] ? 0 : 1;
            a_m_req = r; a_s_addr_ok = 1'b1; a_s_data_ok = 1'b0;
            #1;
            total++; if (a_m_addr_ok !== 2'(1 << g)) begin bad++; $display("[TB] FAIL wrap_push t=%0d got=%b want=%b", t, a_m_addr_ok, 2'(1 << g)); end
            exp_q.push_back(g);
        end
        while (exp_q.size() > 0) begin
            @(negedge clk);
            a_m_req = '0; a_s_addr_ok = 1'b0; a_s_data_ok = 1'b1;
            #1;
            total++; if (a_m_data_ok !== 2'(1 << exp_q[0])) begin bad++; $display("[TB] FAIL wrap_drain got=%b want=%b", a_m_data_ok, 2'(1 << exp_q[0])); end
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        a_idle();
        #1;
        total++; if (a_outstanding !== 2'd0) begin bad++; $display("[TB] FAIL wrap_empty got=%0d want=0", a_outstanding); end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        a_idle();
        a_m_req = 2'b10; a_s_addr_ok = 1'b1;
        #1;
        total++; if (a_m_addr_ok !== 2'b10) begin bad++; $display("[TB] FAIL simul_first got=%b want=10", a_m_addr_ok); end
        @(negedge clk);
        a_m_req = 2'b01; a_s_data_ok = 1'b1; a_s_rdata = 32'h5a5a_5a5a;
        #1;
        total++; if (a_m_addr_ok !== 2'b01 || a_m_data_ok !== 2'b10) begin bad++; $display("[TB] FAIL simul_both got=%b/%b want=01/10", a_m_addr_ok, a_m_data_ok); end
        @(negedge clk);
        a_m_req = '0; a_s_addr_ok = 1'b0; a_s_data_ok = 1'b0;
        #1;
        total++; if (a_outstanding !== 2'd1) begin bad++; $display("[TB] FAIL simul_count got=%0d want=1", a_outstanding); end
        @(negedge clk);
        a_s_data_ok = 1'b1;
        #1;
        total++; if (a_m_data_ok !== 2'b01) begin bad++; $display("[TB] FAIL simul_second got=%b want=01", a_m_data_ok); end
        @(negedge clk);
        a_idle();
        #1;
        total++; if (a_outstanding !== 2'd0) begin bad++; $display("[TB] FAIL simul_empty got=%0d want=0", a_outstanding); end
    endtask

    task automatic test_reset_error();
        @(negedge clk);
        a_idle();
        a_m_req = 2'b11; a_s_addr_ok = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a_idle();
        #1;
        total++; if (a_outstanding !== 2'd2) begin bad++; $display("[TB] FAIL rst_pre got=%0d want=2", a_outstanding); end
        @(negedge clk);
        resetn = 1'b0; a_s_data_ok = 1'b1;
        #1;
        total++; if (a_m_data_ok !== 2'b00) begin bad++; $display("[TB] FAIL rst_data_ok got=%b want=00", a_m_data_ok); end
        @(negedge clk);
        resetn = 1'b1; a_s_data_ok = 1'b0;
        #1;
        total++; if (a_outstanding !== 2'd0 || a_err !== 1'b0) begin bad++; $display("[TB] FAIL rst_cleared got=%0d/%b want=0/0", a_outstanding, a_err); end
        @(negedge clk);
        a_s_data_ok = 1'b1;
        #1;
        total++; if (a_m_data_ok !== 2'b00) begin bad++; $display("[TB] FAIL spurious_data_ok got=%b want=00", a_m_data_ok); end
        @(negedge clk);
        a_s_data_ok = 1'b0;
        #1;
        total++; if (a_err !== 1'b1 || a_outstanding !== 2'd0) begin bad++; $display("[TB] FAIL spurious_err got=%b/%0d want=1/0", a_err, a_outstanding); end
        repeat (3) @(negedge clk);
        #1;
        total++; if (a_err !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky got=%b want=1", a_err); end
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        total++; if (a_err !== 1'b0) begin bad++; $display("[TB] FAIL err_cleared got=%b want=0", a_err); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        @(negedge clk);
        b_idle();
        b_m_req = 3'b011; b_s_addr_ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                @(negedge clk);
                b_s_data_ok = 1'b1;
            end
            exp = (c % 2 == 0) ? 3'b001 : 3'b010;
            #1;
            total++; if (b_m_addr_ok !== exp) begin bad++; $display("[TB] FAIL rr_grant cycle=%0d got=%b want=%b", c, b_m_addr_ok, exp); end
        end
        @(negedge clk);
        b_m_req = '0; b_s_addr_ok = 1'b0; b_s_data_ok = 1'b1;
        @(negedge clk);
        b_idle();
        #1;
        total++; if (b_outstanding !== 3'd0) begin bad++; $display("[TB] FAIL rr_empty got=%0d want=0", b_outstanding); end
    endtask

    // Reference: masters hold requests until accepted; the model applies the grant,
    // lock, full and in-order return rules using a queue of owner IDs.
    task automatic test_random();
        int q[$];
        bit lk;
        int lk_id, rp, g;
        bit err_m, found, ereq, eacc, eret;
        logic [2:0]  pend;
        logic [31:0] paddr [3];
        logic        pwr   [3];
        logic [1:0]  psize [3];
        logic [2:0]  eaok, edok;
        lk = 0; lk_id = 0; rp = 0; err_m = 0; pend = '0;
        for (int m = 0; m < 3; m++) begin paddr[m] = '0; pwr[m] = 1'b0; psize[m] = '0; end
        @(negedge clk);
        resetn = 1'b0;
        b_idle();
        @(negedge clk);
        resetn = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) @(negedge clk);
            for (int m = 0; m < 3; m++) begin
                if (!pend[m] && $urandom_range(0, 2) == 0) begin
                    pend[m]  = 1'b1;
                    paddr[m] = $urandom;
                    pwr[m]   = 1'($urandom_range(0, 1));
                    psize[m] = 2'($urandom_range(0, 2));
                end
                b_m_addr[m*32 +: 32] = paddr[m];
                b_m_wr[m]            = pwr[m];
                b_m_size[m*2 +: 2]   = psize[m];
            end
            b_m_req     = pend;
            b_s_addr_ok = 1'($urandom_range(0, 1));
            b_s_data_ok = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            b_s_rdata   = $urandom;

            ereq = (pend != 3'b000) && (q.size() < 4);
            g = 0;
            if (lk) begin
                g = lk_id;
            end else begin
                found = 0;
                for (int k = 0; k < 3; k++) begin
                    if (!found && pend[(rp + k) % 3]) begin
                        found = 1;
                        g = (rp + k) % 3;
                    end
                end
            end
            eacc = ereq && b_s_addr_ok;
            eaok = eacc ? 3'(1 << g) : 3'b000;
            eret = b_s_data_ok && (q.size() > 0);
            edok = eret ? 3'(1 << q[0]) : 3'b000;
            #1;
            total++; if (b_s_req !== ereq) begin bad++; $display("[TB] FAIL rnd_s_req cyc=%0d got=%b want=%b", cyc, b_s_req, ereq); end
            if (ereq) begin
                total++; if (b_s_addr !== paddr[g] || b_s_wr !== pwr[g] || b_s_size !== psize[g]) begin
                    bad++; $display("[TB] FAIL rnd_fields cyc=%0d got=%h/%b/%0d want=%h/%b/%0d", cyc, b_s_addr, b_s_wr, b_s_size, paddr[g], pwr[g], psize[g]);
                end
            end
            total++; if (b_m_addr_ok !== eaok) begin bad++; $display("[TB] FAIL rnd_addr_ok cyc=%0d got=%b want=%b", cyc, b_m_addr_ok, eaok); end
            total++; if (b_m_data_ok !== edok) begin bad++; $display("[TB] FAIL rnd_data_ok cyc=%0d got=%b want=%b", cyc, b_m_data_ok, edok); end
            total++; if (b_outstanding !== 3'(q.size())) begin bad++; $display("[TB] FAIL rnd_outstanding cyc=%0d got=%0d want=%0d", cyc, b_outstanding, q.size()); end
            total++; if (b_err !== err_m) begin bad++; $display("[TB] FAIL rnd_err cyc=%0d got=%b want=%b", cyc, b_err, err_m); end

            if (b_s_data_ok && q.size() == 0) err_m = 1;
            if (eret) void'(q.pop_front());
            if (eacc) begin
                q.push_back(g);
                pend[g] = 1'b0;
                lk = 0;
                rp = (g + 1) % 3;
            end else if (ereq) begin
                lk = 1;
                lk_id = g;
            end
        end
        @(negedge clk);
        b_idle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetn = 1'b0;
        a_idle();
        b_idle();
        test_reset();
        test_single_read();
        test_fixed_priority();
        test_lock();
        test_full_wrap();
        test_simultaneous();
        test_reset_error();
        test_round_robin();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
